// File: rtl/cp0_exc_ctrl_if.sv
// Fetch-redirect / CP0 access bundle between the M stage (master) and the
// CP0 exception controller (slave).
interface cp0_exc_ctrl_if;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        WE;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        Req;
    logic [31:0] EPCOut;
    logic [31:0] DOut;

    // Req is a single-cycle qualifier: whenever it is high at a rising edge the
    // controller commits the exception and the PC loads the handler at that edge;
    // there is no back-pressure, so it must be honoured even while stalled.
    modport master (
        output A1, A2, DIn, WE, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
        input  Req, EPCOut, DOut
    );
    modport slave (
        input  A1, A2, DIn, WE, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
        output Req, EPCOut, DOut
    );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception controller: SR/Cause/EPC/PRId, interrupt and
// exception request generation, victim-PC capture for the M stage.
module cp0_exc_ctrl #(
    parameter logic [31:0] PRID_VAL = 32'h2024_0829
) (
    input  logic             clk,
    input  logic             RESET_N,
    cp0_exc_ctrl_if.slave    bus
);

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [29:0] epc_word;

    logic        int_req;
    logic        exc_req;
    logic        req;
    logic [31:0] victim_pc;
    logic        unused_bits;

    assign int_req = (|(bus.HWInt & sr_im)) & sr_ie & ~sr_exl;
    assign exc_req = (bus.ExcCodeIn != 5'd0) & ~sr_exl;
    // Gated by reset so the redirect drops the instant reset asserts.
    assign req     = (int_req | exc_req) & RESET_N;

    assign victim_pc   = bus.BDIn ? (bus.VPC - 32'd4) : bus.VPC;
    assign unused_bits = ^{bus.DIn[31:16], bus.DIn[9:2], victim_pc[1:0]};

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc_word  <= '0;
        end else begin
            cause_ip <= bus.HWInt;
            if (req) begin
                sr_exl    <= 1'b1;
                cause_bd  <= bus.BDIn;
                cause_exc <= int_req ? 5'd0 : bus.ExcCodeIn;
                epc_word  <= victim_pc[31:2];
            end else begin
                if (bus.WE && bus.A2 == 5'd12) begin
                    sr_im  <= bus.DIn[15:10];
                    sr_exl <= bus.DIn[1];
                    sr_ie  <= bus.DIn[0];
                end
                if (bus.WE && bus.A2 == 5'd14) begin
                    epc_word <= bus.DIn[31:2];
                end
                // Later assignment wins: eret beats a same-cycle SR write of EXL.
                if (bus.EXLClr) begin
                    sr_exl <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        bus.DOut = 32'd0;
        case (bus.A1)
            5'd12:   bus.DOut = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
            5'd13:   bus.DOut = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'd0};
            5'd14:   bus.DOut = {epc_word, 2'b00};
            5'd15:   bus.DOut = PRID_VAL;
            default: bus.DOut = 32'd0;
        endcase
    end

    assign bus.Req    = req;
    assign bus.EPCOut = {epc_word, 2'b00};

endmodule
